arduino_addr_buffer: RTL

ARDUINO_ADDR_BUFFER -- requirements
Module: arduino_addr_buffer

---
 rtl/arduino_pkg.sv | 8 +
 rtl/sync_edge.sv | 32 +++
 rtl/arduino_addr_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/arduino_pkg.sv
// Shared constants and types for the Arduino address capture path.
package arduino_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 20;

    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// Produces a single-cycle pulse per low-to-high transition of d.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/arduino_addr_buffer.sv
// Captures addresses on an asynchronous Arduino strobe into a small
// first-word fall-through FIFO, with held last address and sticky overflow.
module arduino_addr_buffer
    import arduino_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          addr_in,
    input  logic                       strobe_in,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          last_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              ovf_q, ovf_d;

    logic push, pop, full, wr_en, drop;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (strobe_in),
        .rise (push)
    );

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = (count_q != '0) && out_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = ovf_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = addr_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            last_d          = addr_in;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end

        // A fresh drop outranks a clear on the same edge.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_addr  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign last_addr = last_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule
